// File: rtl/sorter_nch.sv
// N-channel timestamp merge sorter: drains per-link rx FIFOs and emits words in
// wrap-safe timestamp order. Silent links time out so they cannot stall the merge.

module sorter_nch_ch #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              empty,
    input  logic [DATA_W-1:0] din,
    input  logic              pick,
    output logic              rden,
    output logic [DATA_W-1:0] head,
    output logic              vld,
    output logic              stale,
    output logic              drop
);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    logic           inflight;
    logic [TCW-1:0] tcnt;

    // Enabled channels keep one head and one read in flight at most; disabled ones drain freely.
    assign rden  = !rst && !empty && (!en || (!vld && !inflight));
    assign stale = (tcnt >= TCW'(TIMEOUT_CYC));
    assign drop  = !en && (vld || inflight);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            vld      <= 1'b0;
            head     <= '0;
            tcnt     <= '0;
        end else begin
            inflight <= rden;
            if (inflight && en) begin
                head <= din;
                vld  <= 1'b1;
            end else if (vld && (!en || pick)) begin
                vld <= 1'b0;
            end
            if (!en || vld)
                tcnt <= '0;
            else if (!stale)
                tcnt <= tcnt + 1'b1;
        end
    end
endmodule

module sorter_nch #(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 32,
    parameter int TS_W        = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_en_i,
    input  logic [NUM_CH*DATA_W-1:0] rdfifo_data_i,
    input  logic [NUM_CH-1:0]        rdfifo_empty_i,
    output logic [NUM_CH-1:0]        rdfifo_rden_o,
    output logic [DATA_W-1:0]        wrfifo_data_o,
    input  logic                     wrfifo_prog_full_i,
    output logic                     wrfifo_wren_o,
    output logic [15:0]              drop_cnt_o
);
    localparam int SW  = $clog2(NUM_CH);
    localparam int DCW = $clog2(NUM_CH + 1);

    typedef enum logic {FILL, PICK} state_t;

    state_t                         state, state_nxt;
    logic [NUM_CH-1:0][DATA_W-1:0]  head;
    logic [NUM_CH-1:0][TS_W-1:0]    ts;
    logic [NUM_CH-1:0]              vld, stale, drop, pick, cand;
    logic [SW-1:0]                  sel;
    logic                           any, fill_ok, do_pick;
    logic [DCW-1:0]                 ndrop;
    logic [16:0]                    drop_sum;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sorter_nch_ch #(.DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_ch (
            .clk   (clk),
            .rst   (rst),
            .en    (ch_en_i[g]),
            .empty (rdfifo_empty_i[g]),
            .din   (rdfifo_data_i[DATA_W*g +: DATA_W]),
            .pick  (pick[g]),
            .rden  (rdfifo_rden_o[g]),
            .head  (head[g]),
            .vld   (vld[g]),
            .stale (stale[g]),
            .drop  (drop[g])
        );
        assign ts[g]   = head[g][DATA_W-1 -: TS_W];
        assign pick[g] = do_pick && (sel == SW'(g));
    end

    // a precedes b when the modular difference is "negative"
    function automatic logic precedes(input logic [TS_W-1:0] a, input logic [TS_W-1:0] b);
        logic [TS_W-1:0] d;
        d = a - b;
        return d[TS_W-1];
    endfunction

    assign cand    = ch_en_i & vld;
    assign fill_ok = (&(~ch_en_i | vld | stale)) && (|cand);
    assign do_pick = (state == PICK) && !wrfifo_prog_full_i && any;

    // Strict compare while scanning upward keeps ties on the lowest index.
    always_comb begin
        sel = '0;
        any = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cand[i] && (!any || precedes(ts[i], ts[sel]))) begin
                sel = SW'(i);
                any = 1'b1;
            end
        end
    end

    always_comb begin
        ndrop = '0;
        for (int i = 0; i < NUM_CH; i++)
            ndrop = ndrop + DCW'(drop[i]);
    end

    assign drop_sum = {1'b0, drop_cnt_o} + 17'(ndrop);

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (fill_ok) state_nxt = PICK;
            PICK:    if (!wrfifo_prog_full_i) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FILL;
            wrfifo_wren_o <= 1'b0;
            wrfifo_data_o <= '0;
            drop_cnt_o    <= '0;
        end else begin
            state         <= state_nxt;
            wrfifo_wren_o <= do_pick;
            if (do_pick)
                wrfifo_data_o <= head[sel];
            drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
endmodule

// File: tb/tb_sorter_nch.sv
// Scoreboard bench for sorter_nch: FIFO models feed directed words, a negedge
// monitor pops hand-ordered expectations whenever a word is written out.

module tb_sorter_nch;
    localparam int NUM_CH = 8;
    localparam int DATA_W = 32;
    localparam int TS_W   = 16;
    localparam int TMO    = 64;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        ch_en;
    logic [NUM_CH*DATA_W-1:0] rdata = '0;
    logic [NUM_CH-1:0]        empty;
    logic [NUM_CH-1:0]        rden;
    logic [DATA_W-1:0]        wdata;
    logic                     pf;
    logic                     wren;
    logic [15:0]              drop_cnt;

    sorter_nch #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TS_W(TS_W), .TIMEOUT_CYC(TMO)) dut (
        .clk                (clk),
        .rst                (rst),
        .ch_en_i            (ch_en),
        .rdfifo_data_i      (rdata),
        .rdfifo_empty_i     (empty),
        .rdfifo_rden_o      (rden),
        .wrfifo_data_o      (wdata),
        .wrfifo_prog_full_i (pf),
        .wrfifo_wren_o      (wren),
        .drop_cnt_o         (drop_cnt)
    );

    always #5 clk = ~clk;

    // standard-read FIFO models
    logic [DATA_W-1:0] mem [NUM_CH][64];
    int wp [NUM_CH] = '{default: 0};
    int rp [NUM_CH] = '{default: 0};

    always_comb begin
        empty = '0;
        for (int i = 0; i < NUM_CH; i++)
            empty[i] = (wp[i] == rp[i]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rden[i] && (wp[i] != rp[i])) begin
                rdata[DATA_W*i +: DATA_W] <= mem[i][rp[i] % 64];
                rp[i] <= rp[i] + 1;
            end
        end
    end

    int total = 0;
    int bad   = 0;
    int n_out = 0;
    logic prev_wren = 1'b0;
    logic [DATA_W-1:0] exp_q[$];

    function automatic logic [DATA_W-1:0] mk(input int ch, input logic [15:0] ts, input logic [7:0] tag);
        logic [7:0] c;
        c = 8'(ch);
        return {ts, c, tag};
    endfunction

    task automatic load(input int ch, input logic [15:0] ts, input logic [7:0] tag);
        mem[ch][wp[ch] % 64] = mk(ch, ts, tag);
        wp[ch] = wp[ch] + 1;
    endtask

    task automatic expect_w(input int ch, input logic [15:0] ts, input logic [7:0] tag);
        exp_q.push_back(mk(ch, ts, tag));
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic wait_outs(input string nm, input int target, input int budget);
        int c;
        c = 0;
        while (n_out < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (n_out < target) begin
            bad++;
            $display("FAIL %s timeout outputs=%0d want=%0d", nm, n_out, target);
        end
    endtask

    // monitor: scoreboard pop on every written word, plus back-to-back check
    always @(negedge clk) begin
        logic [DATA_W-1:0] w;
        if (!rst) begin
            if (wren && prev_wren) begin
                total++;
                bad++;
                $display("FAIL back_to_back wren high two cycles");
            end
            if (wren) begin
                n_out++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out got=%h want=none", wdata);
                end else begin
                    w = exp_q.pop_front();
                    if (wdata !== w) begin
                        bad++;
                        $display("FAIL out_order got=%h want=%h", wdata, w);
                    end
                end
            end
        end
        prev_wren = wren;
    end

    initial begin
        int base;
        rst   = 1'b1;
        ch_en = '0;
        pf    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wren", 32'(wren), 32'd0);
        chk("rst_data", wdata, 32'd0);
        chk("rst_rden", 32'(rden), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // basic merge across two channels
        ch_en = 8'h09;
        load(0, 16'd5, 8'd1); load(0, 16'd9, 8'd2); load(3, 16'd7, 8'd1);
        expect_w(0, 16'd5, 8'd1); expect_w(3, 16'd7, 8'd1); expect_w(0, 16'd9, 8'd2);
        wait_outs("t1", n_out + 3, 400);
        ch_en = '0;
        repeat (3) @(negedge clk);

        // equal timestamps -> lower index first
        ch_en = 8'h06;
        load(1, 16'h0100, 8'hA1); load(2, 16'h0100, 8'hB2);
        expect_w(1, 16'h0100, 8'hA1); expect_w(2, 16'h0100, 8'hB2);
        wait_outs("t2", n_out + 2, 400);
        ch_en = '0;
        repeat (3) @(negedge clk);

        // timestamp wrap
        ch_en = 8'h03;
        load(0, 16'hFFF0, 8'd3); load(1, 16'h0005, 8'd3);
        expect_w(0, 16'hFFF0, 8'd3); expect_w(1, 16'h0005, 8'd3);
        wait_outs("t3", n_out + 2, 400);
        ch_en = '0;
        repeat (3) @(negedge clk);

        // empty channel times out, later re-joins with an early timestamp
        ch_en = 8'h07;
        load(0, 16'h0010, 8'd4); load(0, 16'h0030, 8'd5); load(1, 16'h0020, 8'd4);
        expect_w(0, 16'h0010, 8'd4); expect_w(1, 16'h0020, 8'd4);
        expect_w(2, 16'h0003, 8'd4); expect_w(0, 16'h0030, 8'd5);
        base = n_out;
        repeat (50) @(negedge clk);
        chk("t4_hold", 32'(n_out), 32'(base));
        wait_outs("t4a", base + 2, 200);
        load(2, 16'h0003, 8'd4);
        wait_outs("t4b", base + 4, 400);
        ch_en = '0;
        repeat (3) @(negedge clk);

        // backpressure holds output; first word one cycle after release
        pf    = 1'b1;
        ch_en = 8'h03;
        load(0, 16'h0050, 8'd6); load(0, 16'h0060, 8'd7); load(1, 16'h0040, 8'd6);
        expect_w(1, 16'h0040, 8'd6); expect_w(0, 16'h0050, 8'd6); expect_w(0, 16'h0060, 8'd7);
        base = n_out;
        repeat (20) begin
            @(negedge clk);
            chk("t5_wren_low", 32'(wren), 32'd0);
        end
        chk("t5_rden_held", 32'(rden), 32'd0);
        pf = 1'b0;
        @(negedge clk);
        chk("t5_latency", 32'(wren), 32'd1);
        chk("t5_first", wdata, mk(1, 16'h0040, 8'd6));
        wait_outs("t5", base + 3, 400);
        ch_en = '0;
        repeat (3) @(negedge clk);

        // disabled channel drained and counted, never output
        base = n_out;
        load(4, 16'h0070, 8'd1); load(4, 16'h0071, 8'd2); load(4, 16'h0072, 8'd3);
        repeat (10) @(negedge clk);
        chk("t6_drop3", 32'(drop_cnt), 32'd3);
        chk("t6_drained", 32'(rp[4]), 32'(wp[4]));
        pf    = 1'b1;
        ch_en = 8'h10;
        load(4, 16'h0080, 8'd4);
        repeat (6) @(negedge clk);
        ch_en = '0;
        repeat (3) @(negedge clk);
        chk("t6_head_drop", 32'(drop_cnt), 32'd4);
        pf = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_no_out", 32'(n_out), 32'(base));
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        // asynchronous reset mid-stream
        ch_en = 8'h03;
        load(0, 16'h0090, 8'd8); load(1, 16'h0091, 8'd8);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_data", wdata, 32'd0);
        chk("arst_wren", 32'(wren), 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        chk("arst_rden", 32'(rden), 32'd0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
